// File: rtl/ysyx_040066_cache_axi_bridge_pkg.sv
// Shared definitions for the cache-to-AXI bridge.
// Contents:
//   - geometry: ADDR_W, DATA_W, BEATS, LINE_W, CNT_W, LINE_BYTES
//   - AXI burst constants: BURST_INCR, SIZE_8B, LEN_LINE
//   - resp_e : AXI response codes
//   - state_e: bridge FSM states
//   - line_align(): clears the byte-within-line address bits
package ysyx_040066_axi_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int BEATS      = 8;
  localparam int LINE_W     = BEATS * DATA_W;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int LINE_BYTES = LINE_W / 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'd3;
  localparam logic [7:0] LEN_LINE   = 8'd7;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_DONE
  } state_e;

  // A masking form is used so every address bit participates in the result.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/ysyx_040066_cache_axi_bridge_if.sv
// Bus bundles used by the cache-to-AXI bridge.
//   ysyx_040066_cache_if : cache-side refill/writeback requests.
//     master = cache, slave = bridge.
//   ysyx_040066_axi_if   : AXI4 AR/R/AW/W/B channels.
//     master = bridge, slave = crossbar/memory.
interface ysyx_040066_cache_if;
  import ysyx_040066_axi_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              rd_req;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_error;
  logic              wr_req;
  logic [LINE_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_error;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_ready, rd_data, rd_last, rd_error, wr_ready, wr_error
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_ready, rd_data, rd_last, rd_error, wr_ready, wr_error
  );
endinterface

interface ysyx_040066_axi_if;
  import ysyx_040066_axi_pkg::*;

  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
           awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid,
           awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
           awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid,
           awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_040066_line_serializer.sv
// Holds a latched 512-bit cache line and presents it one 64-bit dword at a
// time for the AXI W channel.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_line and restart at dword 0
//   i_line         : full cache line, dword 0 in the low bits
//   i_advance      : current beat accepted (wvalid & wready)
//   o_wdata        : dword selected by the beat counter
//   o_wlast        : counter is on the final dword
module ysyx_040066_line_serializer
  import ysyx_040066_axi_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_advance,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wlast
);

  logic [LINE_W-1:0] r_line;
  logic [CNT_W-1:0]  r_cnt;

  // Line contents are don't-care after reset, so the buffer carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_line <= i_line;
    end
  end

  // The counter wraps back to 0 after the final beat, ready for the next line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_advance) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_wdata = r_line[int'(r_cnt) * DATA_W +: DATA_W];
  assign o_wlast = (r_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/ysyx_040066_cache_axi_bridge.sv
// Converts cache line refill / writeback requests into single 8-beat INCR
// AXI4 bursts, one transaction at a time.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cache      : cache-side request bundle (slave modport)
//   axi        : AXI4 master bundle towards the crossbar
module ysyx_040066_cache_axi_bridge
  import ysyx_040066_axi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ysyx_040066_cache_if.slave cache,
  ysyx_040066_axi_if.master  axi
);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_aw_done;
  logic              r_w_done;

  logic              w_accept_wr;
  logic              w_accept_rd;
  logic              w_aw_fire;
  logic              w_w_fire;
  logic              w_w_last_fire;
  logic              w_aw_ok;
  logic              w_w_ok;
  logic [DATA_W-1:0] w_ser_data;
  logic              w_ser_last;
  logic              w_unused;

  // Writeback wins when both requests are raised together.
  assign w_accept_wr   = (r_state == S_IDLE) && cache.wr_req;
  assign w_accept_rd   = (r_state == S_IDLE) && !cache.wr_req && cache.rd_req;
  assign w_aw_fire     = (r_state == S_WR) && !r_aw_done && axi.awready;
  assign w_w_fire      = (r_state == S_WR) && !r_w_done && axi.wready;
  assign w_w_last_fire = w_w_fire && w_ser_last;
  // Either channel may finish first, or both in the same cycle.
  assign w_aw_ok       = r_aw_done || w_aw_fire;
  assign w_w_ok        = r_w_done || w_w_last_fire;

  // Only bit 1 of a response distinguishes error from success.
  assign w_unused = ^{axi.rresp[0], axi.bresp[0]};

  ysyx_040066_line_serializer u_serializer (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_load    (w_accept_wr),
    .i_line    (cache.wr_data),
    .i_advance (w_w_fire),
    .o_wdata   (w_ser_data),
    .o_wlast   (w_ser_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cache.wr_req) begin
          w_next = S_WR;
        end else if (cache.rd_req) begin
          w_next = S_AR;
        end
      end
      S_AR:    if (axi.arready) w_next = S_R;
      S_R:     if (axi.rvalid && axi.rlast) w_next = S_DONE;
      S_WR:    if (w_aw_ok && w_w_ok) w_next = S_B;
      S_B:     if (axi.bvalid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address is captured only at accept, so later cache-side changes are ignored.
  // Channel-done flags are cleared in IDLE, ready for the next writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_accept_wr || w_accept_rd) begin
        r_addr <= line_align(cache.addr);
      end
      if (r_state == S_IDLE) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_fire)     r_aw_done <= 1'b1;
        if (w_w_last_fire) r_w_done  <= 1'b1;
      end
    end
  end

  // Output logic: refill beats are forwarded combinationally, no buffering.
  always_comb begin
    axi.araddr     = r_addr;
    axi.arlen      = LEN_LINE;
    axi.arsize     = SIZE_8B;
    axi.arburst    = BURST_INCR;
    axi.arvalid    = 1'b0;
    axi.rready     = 1'b0;
    axi.awaddr     = r_addr;
    axi.awlen      = LEN_LINE;
    axi.awsize     = SIZE_8B;
    axi.awburst    = BURST_INCR;
    axi.awvalid    = 1'b0;
    axi.wdata      = '0;
    axi.wstrb      = '1;
    axi.wlast      = 1'b0;
    axi.wvalid     = 1'b0;
    axi.bready     = 1'b0;
    cache.rd_ready = 1'b0;
    cache.rd_data  = '0;
    cache.rd_last  = 1'b0;
    cache.rd_error = 1'b0;
    cache.wr_ready = 1'b0;
    cache.wr_error = 1'b0;
    case (r_state)
      S_AR: axi.arvalid = 1'b1;
      S_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          cache.rd_ready = 1'b1;
          cache.rd_data  = axi.rdata;
          cache.rd_error = axi.rresp[1];
          cache.rd_last  = axi.rlast;
        end
      end
      S_WR: begin
        axi.awvalid = !r_aw_done;
        axi.wvalid  = !r_w_done;
        if (!r_w_done) begin
          axi.wdata = w_ser_data;
          axi.wlast = w_ser_last;
        end
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          cache.wr_ready = 1'b1;
          cache.wr_error = axi.bresp[1];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_040066_cache_axi_bridge.sv
// Self-checking bench for ysyx_040066_cache_axi_bridge. Stimulus tasks push
// expected AR/AW addresses, W beats, refill beats and write responses into
// queues; a negedge monitor pops and compares each time the DUT presents one.
module tb_ysyx_040066_cache_axi_bridge;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycleCnt;
  int   arRiseCyc;
  int   wrReadyCyc;
  logic arvalidPrev;

  logic [31:0] arQ[$];
  logic [31:0] awQ[$];
  logic [64:0] wQ[$];
  logic [65:0] rdQ[$];
  logic        bQ[$];

  logic [31:0] mA;
  logic [64:0] mW;
  logic [65:0] mR;
  logic        mB;

  ysyx_040066_cache_if cif ();
  ysyx_040066_axi_if   aif ();

  ysyx_040066_cache_axi_bridge dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cache (cif),
    .axi   (aif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=handshake required=none", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aif.arvalid && !arvalidPrev) arRiseCyc = cycleCnt;
      if (aif.arvalid && aif.arready) begin
        if (arQ.size() == 0) reportUnexpected("ar_unexpected");
        else begin
          mA = arQ.pop_front();
          checkOutput("araddr", aif.araddr, mA);
          checkOutput("ar_fields", {aif.arlen, aif.arsize, aif.arburst}, {8'd7, 3'd3, 2'b01});
        end
      end
      if (aif.awvalid && aif.awready) begin
        if (awQ.size() == 0) reportUnexpected("aw_unexpected");
        else begin
          mA = awQ.pop_front();
          checkOutput("awaddr", aif.awaddr, mA);
          checkOutput("aw_fields", {aif.awlen, aif.awsize, aif.awburst}, {8'd7, 3'd3, 2'b01});
        end
      end
      if (aif.wvalid && aif.wready) begin
        if (wQ.size() == 0) reportUnexpected("w_unexpected");
        else begin
          mW = wQ.pop_front();
          checkOutput("w_beat", {aif.wlast, aif.wdata}, mW);
          checkOutput("wstrb", aif.wstrb, 8'hFF);
        end
      end
      if (cif.rd_ready) begin
        if (rdQ.size() == 0) reportUnexpected("rd_unexpected");
        else begin
          mR = rdQ.pop_front();
          checkOutput("rd_beat", {cif.rd_error, cif.rd_last, cif.rd_data}, mR);
        end
      end
      if (cif.wr_ready) begin
        wrReadyCyc = cycleCnt;
        if (bQ.size() == 0) reportUnexpected("wr_ready_unexpected");
        else begin
          mB = bQ.pop_front();
          checkOutput("wr_error", cif.wr_error, mB);
        end
      end
    end
    arvalidPrev = aif.arvalid;
  end

  // Refill: AR with optional backpressure, then 8 R beats of base+i.
  task automatic applyStimulusRefill(input logic [31:0] a, input int arDelay, input int errBeat,
                                     input int expLat, input logic [63:0] base);
    logic [31:0] expAddr;
    int n;
    expAddr = {a[31:6], 6'b0};
    arQ.push_back(expAddr);
    for (int i = 0; i < 8; i++) begin
      rdQ.push_back({(i == errBeat), (i == 7), base + 64'(i)});
    end
    cif.addr   = a;
    cif.rd_req = 1'b1;
    n = 0;
    while (!aif.arvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ar_latency", 128'(n), 128'(expLat));
    for (int d = 0; d < arDelay; d++) begin
      checkOutput("ar_hold", {aif.arvalid, aif.rready, aif.araddr}, {1'b1, 1'b0, expAddr});
      @(posedge clk); #1;
    end
    aif.arready = 1'b1;
    @(posedge clk); #1;
    aif.arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      aif.rvalid = 1'b1;
      aif.rdata  = base + 64'(i);
      aif.rresp  = (i == errBeat) ? 2'b10 : 2'b00;
      aif.rlast  = (i == 7);
      @(posedge clk); #1;
    end
    aif.rvalid = 1'b0;
    aif.rlast  = 1'b0;
    aif.rresp  = 2'b00;
    cif.rd_req = 1'b0;
    checkOutput("done_quiet", {aif.rready, aif.arvalid, cif.rd_ready}, 3'b000);
    @(posedge clk); #1;
    checkOutput("idle_quiet", {aif.rready, aif.arvalid, aif.awvalid}, 3'b000);
  endtask

  // Writeback: dword i = 0x1111..11 * i, AW delayed, W optionally throttled.
  task automatic applyStimulusWriteback(input logic [31:0] a, input int awDelay, input bit toggleW,
                                        input logic [1:0] resp, input int bDelay);
    logic [511:0] line;
    logic [31:0]  expAddr;
    int wBeats;
    int n;
    expAddr = {a[31:6], 6'b0};
    for (int i = 0; i < 8; i++) begin
      line[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i);
      wQ.push_back({(i == 7), 64'h1111_1111_1111_1111 * 64'(i)});
    end
    awQ.push_back(expAddr);
    bQ.push_back(resp[1]);
    cif.addr    = a;
    cif.wr_data = line;
    cif.wr_req  = 1'b1;
    @(posedge clk); #1;
    checkOutput("aw_entry", aif.awvalid, 1'b1);
    fork
      begin
        for (int d = 0; d < awDelay; d++) begin
          checkOutput("aw_hold", {aif.awvalid, aif.awaddr}, {1'b1, expAddr});
          @(posedge clk); #1;
        end
        aif.awready = 1'b1;
        @(posedge clk); #1;
        aif.awready = 1'b0;
        checkOutput("aw_drop", aif.awvalid, 1'b0);
      end
      begin
        wBeats = 0;
        n = 0;
        while (wBeats < 8 && n < 64) begin
          aif.wready = toggleW ? ((n % 2) == 0) : 1'b1;
          checkOutput("bready_early", aif.bready, 1'b0);
          if (aif.wvalid && aif.wready) wBeats++;
          @(posedge clk); #1;
          n++;
        end
        aif.wready = 1'b0;
      end
    join
    checkOutput("b_entry", {aif.bready, aif.awvalid, aif.wvalid}, 3'b100);
    for (int d = 0; d < bDelay; d++) begin
      checkOutput("b_wait", {aif.bready, cif.wr_ready}, 2'b10);
      @(posedge clk); #1;
    end
    aif.bvalid = 1'b1;
    aif.bresp  = resp;
    @(posedge clk); #1;
    aif.bvalid = 1'b0;
    aif.bresp  = 2'b00;
    cif.wr_req = 1'b0;
    checkOutput("wr_done_quiet", {cif.wr_ready, aif.bready, aif.arvalid}, 3'b000);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [511:0] line;
    checks = 0;
    errors = 0;
    cycleCnt = 0;
    arRiseCyc = 0;
    wrReadyCyc = 0;
    arvalidPrev = 1'b0;
    rst_n = 1'b0;
    cif.addr = '0;  cif.rd_req = 1'b0; cif.wr_req = 1'b0; cif.wr_data = '0;
    aif.arready = 1'b0; aif.rdata = '0; aif.rresp = 2'b00; aif.rlast = 1'b0; aif.rvalid = 1'b0;
    aif.awready = 1'b0; aif.wready = 1'b0; aif.bresp = 2'b00; aif.bvalid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", {aif.arvalid, aif.rready, aif.awvalid, aif.wvalid, aif.wlast, aif.bready,
                cif.rd_ready, cif.rd_last, cif.rd_error, cif.wr_ready, cif.wr_error}, 11'b0);
    checkOutput("reset_addr", {aif.araddr, aif.awaddr}, 64'b0);
    checkOutput("reset_data", {cif.rd_data, aif.wdata}, 128'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] refill");
    applyStimulusRefill(32'h8000_1234, 0, -1, 1, 64'd0);
    $display("[TB] AR backpressure");
    applyStimulusRefill(32'h8000_40C8, 5, -1, 1, 64'h100);
    $display("[TB] writeback, AW late, W throttled");
    applyStimulusWriteback(32'h9000_0088, 4, 1'b1, 2'b00, 2);
    $display("[TB] refill error on beat 3");
    applyStimulusRefill(32'h8000_2000, 0, 3, 1, 64'hA000);
    $display("[TB] writeback error response");
    applyStimulusWriteback(32'h9000_1FFF, 0, 1'b0, 2'b11, 0);
    $display("[TB] AW and W finish together");
    applyStimulusWriteback(32'h9000_2040, 7, 1'b0, 2'b00, 1);

    $display("[TB] simultaneous requests");
    cif.rd_req = 1'b1;
    applyStimulusWriteback(32'h8000_3000, 10, 1'b0, 2'b00, 0);
    applyStimulusRefill(32'h8000_3000, 0, -1, 1, 64'h55);
    checkOutput("ar_after_done", 128'(arRiseCyc - wrReadyCyc), 128'd3);

    $display("[TB] reset during W beat 4");
    for (int i = 0; i < 8; i++) line[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i);
    for (int i = 0; i < 4; i++) wQ.push_back({1'b0, 64'h1111_1111_1111_1111 * 64'(i)});
    awQ.push_back(32'h0000_2040);
    cif.addr = 32'h0000_2055; cif.wr_data = line; cif.wr_req = 1'b1;
    aif.awready = 1'b1; aif.wready = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("w_beat4", {aif.wvalid, aif.wdata}, {1'b1, 64'h4444_4444_4444_4444});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", {aif.arvalid, aif.awvalid, aif.wvalid, aif.wlast, aif.rready, aif.bready,
                cif.rd_ready, cif.wr_ready}, 8'b0);
    cif.wr_req = 1'b0; aif.awready = 1'b0; aif.wready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulusRefill(32'h8000_5000, 2, -1, 1, 64'h700);
    applyStimulusWriteback(32'h9000_6000, 1, 1'b0, 2'b00, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queues_drained", 128'(arQ.size() + awQ.size() + wQ.size() + rdQ.size() + bQ.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
